xcvr_rst_seq: RTL and testbench

- Reset sequencer for the 10GBASE-R transceiver channel and its TX fPLL. Runs on the free-running global clock (clk/rst from the board-level reset generator).
- Drives fPLL powerdown and the TX/RX analog and digital resets in the required order, gated by PLL lock, calibration-busy and CDR lock.
- Reports tx_ready/rx_ready to the PCS/MAC.
- Recovers automatically from loss of PLL lock or loss of CDR lock.

---
 rtl/xcvr_rst_pkg.sv | 26 ++
 rtl/lock_filter.sv | 54 +++++
 rtl/xcvr_rst_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_xcvr_rst_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xcvr_rst_pkg.sv
// Shared state encodings and helpers for the 10GBASE-R transceiver reset sequencer.
package xcvr_rst_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        PLL_PD   = 3'd0,
        WAIT_PLL = 3'd1,
        TX_ANA   = 3'd2,
        TX_DIG   = 3'd3,
        TX_RDY   = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_ANA   = 2'd0,
        WAIT_CDR = 2'd1,
        RX_DIG   = 2'd2,
        RX_RDY   = 2'd3
    } rx_state_t;

    // True once a dwell counter that started at zero has covered cyc cycles.
    function automatic logic dwell_done(input int unsigned cnt, input int unsigned cyc);
        return (cnt + 32'd1) >= cyc;
    endfunction

endpackage

// File: rtl/lock_filter.sv
// Synchronizes an asynchronous lock indication and debounces it: the output rises
// only after FILT_CYC consecutive high samples and falls on the first low sample.
module lock_filter
    import xcvr_rst_pkg::*;
#(
    parameter int FILT_CYC = 16,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic din,
    output logic lock_f
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   din_s;

    assign din_s = sync_q[SYNC_STAGES-1];

    // clear discards everything seen while the source is known to be meaningless.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d  = cnt_q;
        filt_d = 1'b0;
        if (clear || !din_s) begin
            cnt_d = '0;
        end else if (dwell_done(32'(cnt_q), FILT_CYC)) begin
            filt_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (clear) begin
            sync_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign lock_f = filt_q;

endmodule

// File: rtl/xcvr_rst_seq.sv
// Reset sequencer for a 10GBASE-R channel and its TX fPLL: orders powerdown and
// analog/digital resets. Define XCVR_RST_STATUS_EN for relock counters and state outputs.
module xcvr_rst_seq
    import xcvr_rst_pkg::*;
#(
    parameter int PD_CYC        = 100,
    parameter int ANA_CYC       = 20,
    parameter int DIG_CYC       = 20,
    parameter int LOCK_FILT_CYC = 16,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       pll_cal_busy,
    input  logic       tx_cal_busy,
    input  logic       rx_cal_busy,
    input  logic       rx_is_lockedtodata,
    output logic       pll_powerdown,
    output logic       tx_analogreset,
    output logic       tx_digitalreset,
    output logic       rx_analogreset,
    output logic       rx_digitalreset,
    output logic       tx_ready,
    output logic       rx_ready
`ifdef XCVR_RST_STATUS_EN
    ,
    output logic [7:0] tx_relock_cnt,
    output logic [7:0] rx_relock_cnt,
    output logic [2:0] tx_state,
    output logic [1:0] rx_state
`endif
);

    localparam logic [2:0] S_PLL_PD   = PLL_PD;
    localparam logic [2:0] S_WAIT_PLL = WAIT_PLL;
    localparam logic [2:0] S_TX_ANA   = TX_ANA;
    localparam logic [2:0] S_TX_DIG   = TX_DIG;
    localparam logic [2:0] S_TX_RDY   = TX_RDY;
    localparam logic [1:0] S_RX_ANA   = RX_ANA;
    localparam logic [1:0] S_WAIT_CDR = WAIT_CDR;
    localparam logic [1:0] S_RX_DIG   = RX_DIG;
    localparam logic [1:0] S_RX_RDY   = RX_RDY;

    logic [SYNC_STAGES-1:0] pll_cal_sync_q, pll_cal_sync_d;
    logic [SYNC_STAGES-1:0] tx_cal_sync_q, tx_cal_sync_d;
    logic [SYNC_STAGES-1:0] rx_cal_sync_q, rx_cal_sync_d;
    logic                   pll_cal_busy_s, tx_cal_busy_s, rx_cal_busy_s;
    logic                   pll_lock_f, cdr_f;

    logic [2:0]       tx_state_q, tx_state_d;
    logic [1:0]       rx_state_q, rx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    int unsigned      tx_dwell, rx_dwell;
    logic             tx_done, rx_done, tx_loss, rx_loss;

    logic pll_powerdown_q, pll_powerdown_d;
    logic tx_analogreset_q, tx_analogreset_d;
    logic tx_digitalreset_q, tx_digitalreset_d;
    logic rx_analogreset_q, rx_analogreset_d;
    logic rx_digitalreset_q, rx_digitalreset_d;
    logic tx_ready_q, tx_ready_d;
    logic rx_ready_q, rx_ready_d;

    // Cal-busy synchronizers start out busy so nothing advances on stale samples.
    always_comb begin
        pll_cal_sync_d = {pll_cal_sync_q[SYNC_STAGES-2:0], pll_cal_busy};
        tx_cal_sync_d  = {tx_cal_sync_q[SYNC_STAGES-2:0], tx_cal_busy};
        rx_cal_sync_d  = {rx_cal_sync_q[SYNC_STAGES-2:0], rx_cal_busy};
    end

    assign pll_cal_busy_s = pll_cal_sync_q[SYNC_STAGES-1];
    assign tx_cal_busy_s  = tx_cal_sync_q[SYNC_STAGES-1];
    assign rx_cal_busy_s  = rx_cal_sync_q[SYNC_STAGES-1];

    // Lock is meaningless while the PLL is powered down or the CDR is in analog reset.
    lock_filter #(
        .FILT_CYC (LOCK_FILT_CYC),
        .CNT_W    (CNT_W)
    ) u_pll_lock_filter (
        .clk    (clk),
        .rst    (rst),
        .clear  (pll_powerdown_q),
        .din    (pll_locked),
        .lock_f (pll_lock_f)
    );

    lock_filter #(
        .FILT_CYC (LOCK_FILT_CYC),
        .CNT_W    (CNT_W)
    ) u_cdr_lock_filter (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_analogreset_q),
        .din    (rx_is_lockedtodata),
        .lock_f (cdr_f)
    );

    always_comb begin
        tx_dwell = 0;
        case (tx_state_q)
            S_PLL_PD: tx_dwell = PD_CYC;
            S_TX_ANA: tx_dwell = ANA_CYC;
            S_TX_DIG: tx_dwell = DIG_CYC;
            default:  tx_dwell = 0;
        endcase
        tx_done = dwell_done(32'(tx_cnt_q), tx_dwell);
        tx_loss = !pll_lock_f &&
                  (tx_state_q == S_TX_ANA || tx_state_q == S_TX_DIG || tx_state_q == S_TX_RDY);

        tx_state_d = tx_state_q;
        case (tx_state_q)
            S_PLL_PD:   if (tx_done) tx_state_d = S_WAIT_PLL;
            S_WAIT_PLL: if (pll_lock_f && !pll_cal_busy_s && !tx_cal_busy_s) tx_state_d = S_TX_ANA;
            S_TX_ANA:   if (tx_done) tx_state_d = S_TX_DIG;
            S_TX_DIG:   if (tx_done) tx_state_d = S_TX_RDY;
            S_TX_RDY:   tx_state_d = S_TX_RDY;
            default:    tx_state_d = S_PLL_PD;
        endcase
        // Lock loss overrides any dwell expiry in the same cycle.
        if (tx_loss) tx_state_d = S_WAIT_PLL;

        tx_cnt_d = tx_cnt_q;
        if (tx_state_d != tx_state_q) begin
            tx_cnt_d = '0;
        end else if (!tx_done) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end

        pll_powerdown_d   = (tx_state_d == S_PLL_PD);
        tx_analogreset_d  = (tx_state_d == S_PLL_PD) || (tx_state_d == S_WAIT_PLL) ||
                            (tx_state_d == S_TX_ANA);
        tx_digitalreset_d = (tx_state_d != S_TX_RDY);
        tx_ready_d        = (tx_state_d == S_TX_RDY);
    end

    always_comb begin
        rx_dwell = 0;
        case (rx_state_q)
            S_RX_ANA: rx_dwell = ANA_CYC;
            S_RX_DIG: rx_dwell = DIG_CYC;
            default:  rx_dwell = 0;
        endcase
        rx_done = dwell_done(32'(rx_cnt_q), rx_dwell);
        rx_loss = !cdr_f && (rx_state_q == S_RX_DIG || rx_state_q == S_RX_RDY);

        rx_state_d = rx_state_q;
        case (rx_state_q)
            S_RX_ANA:   if (rx_done && !rx_cal_busy_s) rx_state_d = S_WAIT_CDR;
            S_WAIT_CDR: if (cdr_f) rx_state_d = S_RX_DIG;
            S_RX_DIG:   if (rx_done) rx_state_d = S_RX_RDY;
            default:    rx_state_d = rx_state_q;
        endcase
        if (rx_loss) rx_state_d = S_WAIT_CDR;

        rx_cnt_d = rx_cnt_q;
        if (rx_state_d != rx_state_q) begin
            rx_cnt_d = '0;
        end else if (!rx_done) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
        end

        rx_analogreset_d  = (rx_state_d == S_RX_ANA);
        rx_digitalreset_d = (rx_state_d != S_RX_RDY);
        rx_ready_d        = (rx_state_d == S_RX_RDY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pll_cal_sync_q    <= '1;
            tx_cal_sync_q     <= '1;
            rx_cal_sync_q     <= '1;
            tx_state_q        <= S_PLL_PD;
            rx_state_q        <= S_RX_ANA;
            tx_cnt_q          <= '0;
            rx_cnt_q          <= '0;
            pll_powerdown_q   <= 1'b1;
            tx_analogreset_q  <= 1'b1;
            tx_digitalreset_q <= 1'b1;
            rx_analogreset_q  <= 1'b1;
            rx_digitalreset_q <= 1'b1;
            tx_ready_q        <= 1'b0;
            rx_ready_q        <= 1'b0;
        end else begin
            pll_cal_sync_q    <= pll_cal_sync_d;
            tx_cal_sync_q     <= tx_cal_sync_d;
            rx_cal_sync_q     <= rx_cal_sync_d;
            tx_state_q        <= tx_state_d;
            rx_state_q        <= rx_state_d;
            tx_cnt_q          <= tx_cnt_d;
            rx_cnt_q          <= rx_cnt_d;
            pll_powerdown_q   <= pll_powerdown_d;
            tx_analogreset_q  <= tx_analogreset_d;
            tx_digitalreset_q <= tx_digitalreset_d;
            rx_analogreset_q  <= rx_analogreset_d;
            rx_digitalreset_q <= rx_digitalreset_d;
            tx_ready_q        <= tx_ready_d;
            rx_ready_q        <= rx_ready_d;
        end
    end

    assign pll_powerdown   = pll_powerdown_q;
    assign tx_analogreset  = tx_analogreset_q;
    assign tx_digitalreset = tx_digitalreset_q;
    assign rx_analogreset  = rx_analogreset_q;
    assign rx_digitalreset = rx_digitalreset_q;
    assign tx_ready        = tx_ready_q;
    assign rx_ready        = rx_ready_q;

`ifdef XCVR_RST_STATUS_EN
    logic [7:0] tx_relock_q, tx_relock_d;
    logic [7:0] rx_relock_q, rx_relock_d;

    // Saturating counts of lock-loss exits, for field diagnostics.
    always_comb begin
        tx_relock_d = tx_relock_q;
        rx_relock_d = rx_relock_q;
        if (tx_loss && tx_relock_q != 8'hFF) tx_relock_d = tx_relock_q + 8'd1;
        if (rx_loss && rx_relock_q != 8'hFF) rx_relock_d = rx_relock_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_relock_q <= '0;
            rx_relock_q <= '0;
        end else begin
            tx_relock_q <= tx_relock_d;
            rx_relock_q <= rx_relock_d;
        end
    end

    assign tx_relock_cnt = tx_relock_q;
    assign rx_relock_cnt = rx_relock_q;
    assign tx_state      = tx_state_q;
    assign rx_state      = rx_state_q;
`endif

endmodule

// File: tb/tb_xcvr_rst_seq.sv
// Directed bench for xcvr_rst_seq with PD=4, ANA=3, DIG=3, LOCK_FILT=4.
module tb_xcvr_rst_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b1;
    logic pll_cal_busy = 1'b0;
    logic tx_cal_busy = 1'b0;
    logic rx_cal_busy = 1'b0;
    logic rx_is_lockedtodata = 1'b1;
    logic pll_powerdown, tx_analogreset, tx_digitalreset;
    logic rx_analogreset, rx_digitalreset, tx_ready, rx_ready;
`ifdef XCVR_RST_STATUS_EN
    logic [7:0] tx_relock_cnt, rx_relock_cnt;
    logic [2:0] tx_state;
    logic [1:0] rx_state;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    xcvr_rst_seq #(
        .PD_CYC        (4),
        .ANA_CYC       (3),
        .DIG_CYC       (3),
        .LOCK_FILT_CYC (4),
        .CNT_W         (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pll_locked         (pll_locked),
        .pll_cal_busy       (pll_cal_busy),
        .tx_cal_busy        (tx_cal_busy),
        .rx_cal_busy        (rx_cal_busy),
        .rx_is_lockedtodata (rx_is_lockedtodata),
        .pll_powerdown      (pll_powerdown),
        .tx_analogreset     (tx_analogreset),
        .tx_digitalreset    (tx_digitalreset),
        .rx_analogreset     (rx_analogreset),
        .rx_digitalreset    (rx_digitalreset),
        .tx_ready           (tx_ready),
        .rx_ready           (rx_ready)
`ifdef XCVR_RST_STATUS_EN
        ,
        .tx_relock_cnt      (tx_relock_cnt),
        .rx_relock_cnt      (rx_relock_cnt),
        .tx_state           (tx_state),
        .rx_state           (rx_state)
`endif
    );

    typedef struct {
        int         cyc;
        logic       lk;
        logic       pcb;
        logic       tcb;
        logic       rcb;
        logic       cdr;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[11];

    // {pll_powerdown, tx_ana, tx_dig, rx_ana, rx_dig, tx_ready, rx_ready}
    function automatic logic [6:0] outs();
        return {pll_powerdown, tx_analogreset, tx_digitalreset,
                rx_analogreset, rx_digitalreset, tx_ready, rx_ready};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic set_in(input logic lk, input logic pcb, input logic tcb,
                          input logic rcb, input logic cdr);
        pll_locked = lk;
        pll_cal_busy = pcb;
        tx_cal_busy = tcb;
        rx_cal_busy = rcb;
        rx_is_lockedtodata = cdr;
    endtask

    // cyc 0 is the state just after the last edge that sees rst high.
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_tx_ready(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (tx_ready === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        logic seen;

        vecs[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1111100};
        vecs[1]  = '{2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1111100};
        vecs[2]  = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1110100};
        vecs[3]  = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0110100};
        vecs[4]  = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0110100};
        vecs[5]  = '{12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0110100};
        vecs[6]  = '{13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0110001};
        vecs[7]  = '{14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010001};
        vecs[8]  = '{16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010001};
        vecs[9]  = '{17, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000011};
        vecs[10] = '{20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000011};

        // Clean bring-up
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        foreach (vecs[i]) begin
            set_in(vecs[i].lk, vecs[i].pcb, vecs[i].tcb, vecs[i].rcb, vecs[i].cdr);
            run_to(vecs[i].cyc);
            chk($sformatf("bringup_c%0d", vecs[i].cyc), 32'(outs()), 32'(vecs[i].exp));
        end

        // Calibration delay holds TX in WAIT_PLL
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        run_to(10);
        chk("cal_hold_c10", 32'({pll_powerdown, tx_analogreset, tx_digitalreset, tx_ready}), 32'(4'b0110));
        run_to(59);
        chk("cal_hold_c59", 32'({pll_powerdown, tx_analogreset, tx_digitalreset, tx_ready}), 32'(4'b0110));
        run_to(60);
        pll_cal_busy = 1'b0;
        run_to(65);
        chk("cal_ana_still_c65", 32'(tx_analogreset), 32'd1);
        run_to(66);
        chk("cal_ana_release_c66", 32'(tx_analogreset), 32'd0);
        wait_tx_ready(20, at);
        chk("cal_tx_ready_cyc", 32'(at), 32'd69);

        // Single-cycle PLL lock glitch in TX_RDY
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        run_to(20);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        run_to(23);
        chk("glitch_ready_c23", 32'(tx_ready), 32'd1);
        run_to(24);
        chk("glitch_drop_c24", 32'({pll_powerdown, tx_analogreset, tx_digitalreset, tx_ready, rx_ready}),
            32'(5'b01101));
        run_to(30);
        chk("glitch_ana_c30", 32'(tx_analogreset), 32'd1);
        run_to(31);
        chk("glitch_dig_c31", 32'({tx_analogreset, tx_digitalreset}), 32'(2'b01));
        run_to(33);
        chk("glitch_notready_c33", 32'(tx_ready), 32'd0);
        run_to(34);
        chk("glitch_ready_c34", 32'({tx_analogreset, tx_digitalreset, tx_ready}), 32'(3'b001));
`ifdef XCVR_RST_STATUS_EN
        chk("glitch_relock_cnt", 32'(tx_relock_cnt), 32'd1);
        chk("glitch_tx_state", 32'(tx_state), 32'd4);
`endif

        // Lock bounce never passes the filter
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        seen = 1'b0;
        while (cyc < 60) begin
            pll_locked = (((cyc / 3) % 2) == 0);
            step();
            if (tx_analogreset !== 1'b1 || tx_ready !== 1'b0) seen = 1'b1;
        end
        chk("bounce_ana_released", 32'(seen), 32'd0);
        chk("bounce_wait_pll", 32'({pll_powerdown, tx_analogreset, tx_ready}), 32'(3'b010));

        // CDR loss for 10 cycles in RX_RDY
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        run_to(20);
        rx_is_lockedtodata = 1'b0;
        run_to(23);
        chk("cdr_ready_c23", 32'(rx_ready), 32'd1);
        run_to(24);
        chk("cdr_drop_c24", 32'({rx_analogreset, rx_digitalreset, rx_ready}), 32'(3'b010));
        run_to(30);
        rx_is_lockedtodata = 1'b1;
        run_to(36);
        chk("cdr_wait_c36", 32'({rx_analogreset, rx_digitalreset, rx_ready}), 32'(3'b010));
        run_to(39);
        chk("cdr_notready_c39", 32'(rx_ready), 32'd0);
        run_to(40);
        chk("cdr_recover_c40", 32'({rx_analogreset, rx_digitalreset, rx_ready, tx_ready}), 32'(4'b0011));
`ifdef XCVR_RST_STATUS_EN
        chk("cdr_relock_cnt", 32'(rx_relock_cnt), 32'd1);
`endif

        // Reset pulse during TX_DIG
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        run_to(15);
        chk("rstmid_in_txdig", 32'({tx_analogreset, tx_digitalreset, tx_ready}), 32'(3'b010));
        rst = 1'b1;
        step();
        chk("rstmid_reset_vals", 32'(outs()), 32'(7'b1111100));
`ifdef XCVR_RST_STATUS_EN
        chk("rstmid_tx_state", 32'(tx_state), 32'd0);
`endif
        rst = 1'b0;
        cyc = 0;
        run_to(3);
        chk("rstmid_pd_c3", 32'(pll_powerdown), 32'd1);
        run_to(4);
        chk("rstmid_pd_c4", 32'(pll_powerdown), 32'd0);
        wait_tx_ready(40, at);
        chk("rstmid_tx_ready_cyc", 32'(at), 32'd17);
        chk("latency_formula", 32'(at >= (4 + 4 + 3 + 3 + 2)), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
